weight_pingpong_buffer: RTL and testbench

Parametrised successor to the single-word weight staging register between the weight memory and the systolic array.
- Two banks (active and shadow), each DEPTH words of N_ROWS_ARRAY*F_WIDTH bits.
- The shadow bank is filled from weight memory by an internal read sequencer while the array consumes the active bank.
- A swap handshake exchanges the two banks at a round boundary.
- Sits between the weight memory and the systolic array's f_weight input; driven by the SA controller.

---
 rtl/weight_pingpong_buffer.sv | 177 +++++++++++++++++
 tb/tb_weight_pingpong_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_pingpong_buffer.sv
// Double-banked weight staging between weight memory and the systolic array f_weight input.
// Optional `WEIGHT_ZERO_SKIP_EN stores per-row nonzero flags and drives nz_mask_o from them.
module weight_pingpong_buffer #(
  parameter int N_ROWS_ARRAY   = 16,
  parameter int F_WIDTH        = 8,
  parameter int DEPTH          = 4,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int MEM_LATENCY    = 1,
  parameter int ROUND_WIDTH    = 3
) (
  input  logic                              clk_i,
  input  logic                              rd_weight_rst,
  input  logic                              fill_start_i,
  input  logic [MEM_ADDR_WIDTH-1:0]         fill_base_i,
  output logic                              mem_rd_o,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_addr_o,
  input  logic [N_ROWS_ARRAY*F_WIDTH-1:0]   mem_data_i,
  output logic                              fill_busy_o,
  output logic                              fill_done_o,
  input  logic                              swap_i,
  output logic                              swap_err_o,
  output logic                              active_valid_o,
  input  logic [$clog2(DEPTH)-1:0]          rd_idx_i,
  input  logic                              weight_ld_i,
  output logic [N_ROWS_ARRAY*F_WIDTH-1:0]   f_weight_o,
  output logic [N_ROWS_ARRAY-1:0]           nz_mask_o,
  input  logic [ROUND_WIDTH-1:0]            max_round_i,
  output logic [ROUND_WIDTH-1:0]            round_o,
  output logic                              last_round_o
);

  localparam int W  = N_ROWS_ARRAY * F_WIDTH;
  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FULL  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [IW-1:0]             issue_cnt_q, issue_cnt_d;
  logic [IW-1:0]             cap_cnt_q, cap_cnt_d;
  logic [MEM_LATENCY-1:0]    pipe_q, pipe_d;
  logic [MEM_LATENCY:0]      pipe_ext;
  logic                      act_q, act_d;
  logic                      active_valid_q, active_valid_d;
  logic                      swap_err_q, swap_err_d;
  logic [ROUND_WIDTH-1:0]    round_q, round_d;
  logic [W-1:0]              f_weight_q, f_weight_d;
  logic [W-1:0]              bank_q [2][DEPTH];
  logic                      capture, last_capture, swap_ok, load_ok;

  // Each read token travels MEM_LATENCY stages; the oldest stage marks valid mem_data_i.
  assign pipe_ext     = {pipe_q, mem_rd_o};
  assign pipe_d       = pipe_ext[MEM_LATENCY-1:0];

  assign mem_rd_o     = (state_q == S_ISSUE);
  assign mem_addr_o   = base_q + MEM_ADDR_WIDTH'(issue_cnt_q);
  assign fill_busy_o  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign capture      = pipe_q[MEM_LATENCY-1] && fill_busy_o;
  assign last_capture = capture && (cap_cnt_q == IW'(DEPTH-1));
  assign fill_done_o  = (state_q == S_DRAIN) && last_capture;
  assign swap_ok      = swap_i && (state_q == S_FULL);
  assign load_ok      = weight_ld_i && active_valid_q;

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    issue_cnt_d    = issue_cnt_q;
    cap_cnt_d      = cap_cnt_q;
    act_d          = act_q;
    active_valid_d = active_valid_q;
    round_d        = round_q;
    f_weight_d     = f_weight_q;
    swap_err_d     = swap_i && !swap_ok;
    case (state_q)
      S_IDLE: begin
        if (fill_start_i) begin
          state_d     = S_ISSUE;
          base_d      = fill_base_i;
          issue_cnt_d = '0;
          cap_cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == IW'(DEPTH-1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_capture) state_d = S_FULL;
      end
      default: begin
        if (swap_ok) begin
          state_d        = S_IDLE;
          act_d          = ~act_q;
          active_valid_d = 1'b1;
          round_d        = (round_q == max_round_i) ? '0 : round_q + 1'b1;
        end
      end
    endcase
    if (capture) cap_cnt_d = cap_cnt_q + 1'b1;
    // act_q is the pre-swap pointer, so a load on the swap cycle reads the outgoing bank.
    if (load_ok) f_weight_d = bank_q[act_q][rd_idx_i];
  end

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      issue_cnt_q    <= '0;
      cap_cnt_q      <= '0;
      pipe_q         <= '0;
      act_q          <= 1'b0;
      active_valid_q <= 1'b0;
      swap_err_q     <= 1'b0;
      round_q        <= '0;
      f_weight_q     <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      issue_cnt_q    <= issue_cnt_d;
      cap_cnt_q      <= cap_cnt_d;
      pipe_q         <= pipe_d;
      act_q          <= act_d;
      active_valid_q <= active_valid_d;
      swap_err_q     <= swap_err_d;
      round_q        <= round_d;
      f_weight_q     <= f_weight_d;
    end
  end

  // Bank storage keeps its contents across reset; validity lives in the FSM and active_valid_q.
  always_ff @(posedge clk_i) begin
    if (capture) bank_q[~act_q][cap_cnt_q] <= mem_data_i;
  end

`ifdef WEIGHT_ZERO_SKIP_EN
  logic [N_ROWS_ARRAY-1:0] nz_bank_q [2][DEPTH];
  logic [N_ROWS_ARRAY-1:0] cap_nz;
  logic [N_ROWS_ARRAY-1:0] nz_mask_q, nz_mask_d;

  always_comb begin
    cap_nz = '0;
    for (int r = 0; r < N_ROWS_ARRAY; r++) cap_nz[r] = |mem_data_i[r*F_WIDTH +: F_WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (capture) nz_bank_q[~act_q][cap_nz_idx()] <= cap_nz;
  end

  function automatic logic [IW-1:0] cap_nz_idx();
    return cap_cnt_q;
  endfunction

  always_comb begin
    nz_mask_d = nz_mask_q;
    if (load_ok) nz_mask_d = nz_bank_q[act_q][rd_idx_i];
  end

  always_ff @(posedge clk_i or posedge rd_weight_rst) begin
    if (rd_weight_rst) nz_mask_q <= '0;
    else               nz_mask_q <= nz_mask_d;
  end

  assign nz_mask_o = nz_mask_q;
`else
  assign nz_mask_o = '1;
`endif

  assign swap_err_o     = swap_err_q;
  assign active_valid_o = active_valid_q;
  assign f_weight_o     = f_weight_q;
  assign round_o        = round_q;
  assign last_round_o   = (round_q == max_round_i);

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Bench for weight_pingpong_buffer: latency-modelled weight memory, transaction-level bank model, per-cycle output checks.
module tb_weight_pingpong_buffer;
  localparam int NR    = 16;
  localparam int FW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int LAT   = 2;
  localparam int RW    = 3;
  localparam int W     = NR * FW;
  localparam int IW    = $clog2(DEPTH);
`ifdef WEIGHT_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rd_weight_rst = 1'b1;
  logic          fill_start_i = 1'b0;
  logic [AW-1:0] fill_base_i = '0;
  logic          mem_rd_o;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_data_i = '0;
  logic          fill_busy_o, fill_done_o;
  logic          swap_i = 1'b0;
  logic          swap_err_o, active_valid_o;
  logic [IW-1:0] rd_idx_i = '0;
  logic          weight_ld_i = 1'b0;
  logic [W-1:0]  f_weight_o;
  logic [NR-1:0] nz_mask_o;
  logic [RW-1:0] max_round_i = '0;
  logic [RW-1:0] round_o;
  logic          last_round_o;

  int n_checks = 0;
  int n_errors = 0;

  weight_pingpong_buffer #(
    .N_ROWS_ARRAY(NR), .F_WIDTH(FW), .DEPTH(DEPTH),
    .MEM_ADDR_WIDTH(AW), .MEM_LATENCY(LAT), .ROUND_WIDTH(RW)
  ) dut (
    .clk_i(clk_i), .rd_weight_rst(rd_weight_rst),
    .fill_start_i(fill_start_i), .fill_base_i(fill_base_i),
    .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
    .swap_i(swap_i), .swap_err_o(swap_err_o), .active_valid_o(active_valid_o),
    .rd_idx_i(rd_idx_i), .weight_ld_i(weight_ld_i),
    .f_weight_o(f_weight_o), .nz_mask_o(nz_mask_o),
    .max_round_i(max_round_i), .round_o(round_o), .last_round_o(last_round_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- weight memory ----------------
  logic [W-1:0] mem_m [logic [AW-1:0]];

  function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
    if (!mem_m.exists(a)) mem_m[a] = {$urandom(), $urandom(), $urandom(), $urandom()};
    return mem_m[a];
  endfunction

  // Returns data LAT cycles after the read; cycles with no read return garbage.
  initial begin
    logic          hv[$];
    logic [AW-1:0] ha[$];
    logic          v;
    logic [AW-1:0] a;
    forever begin
      @(posedge clk_i);
      hv.push_back(mem_rd_o);
      ha.push_back(mem_addr_o);
      if (hv.size() >= LAT) begin
        v = hv.pop_front();
        a = ha.pop_front();
        #1 mem_data_i = v ? mem_word(a) : {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
  end

  // ---------------- reference model ----------------
  logic [W-1:0]  m_act [DEPTH];
  logic [W-1:0]  m_shd [DEPTH];
  logic [W-1:0]  m_f;
  logic [NR-1:0] m_nz;
  logic          m_av, m_full, m_err;
  int            m_left;     // cycles until the shadow bank is full; 0 when no fill is running
  logic [AW-1:0] m_base;
  logic [RW-1:0] m_round;
  int            busy_seen, done_seen, err_seen;

  function automatic logic [NR-1:0] nz_of(input logic [W-1:0] w);
    logic [NR-1:0] m;
    for (int r = 0; r < NR; r++) m[r] = (w[r*FW +: FW] != '0);
    return m;
  endfunction

  task automatic model_reset();
    m_av = 1'b0; m_full = 1'b0; m_err = 1'b0; m_left = 0;
    m_f = '0; m_nz = ZS ? '0 : '1; m_round = '0; m_base = '0;
  endtask

  task automatic model_edge();
    logic full0;
    int   left0;
    if (rd_weight_rst) return;
    full0 = m_full;
    left0 = m_left;
    if (weight_ld_i && m_av) begin
      m_f  = m_act[rd_idx_i];
      m_nz = ZS ? nz_of(m_f) : '1;
    end
    m_err = swap_i && !full0;
    if (swap_i && full0) begin
      m_act   = m_shd;
      m_av    = 1'b1;
      m_full  = 1'b0;
      m_round = (m_round == max_round_i) ? '0 : m_round + 1'b1;
    end
    if (fill_start_i && left0 == 0 && !full0) begin
      m_left = DEPTH + LAT;
      m_base = fill_base_i;
    end else if (left0 > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_shd[i] = mem_word(m_base + AW'(i));
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic          exp_rd;
    logic [AW-1:0] exp_addr;
    exp_rd   = (m_left > LAT);
    exp_addr = m_base + AW'(DEPTH + LAT - m_left);
    chk("mem_rd", W'(mem_rd_o), W'(exp_rd));
    if (exp_rd) chk("mem_addr", W'(mem_addr_o), W'(exp_addr));
    chk("fill_busy", W'(fill_busy_o), W'(m_left > 0));
    chk("fill_done", W'(fill_done_o), W'(m_left == 1));
    chk("swap_err", W'(swap_err_o), W'(m_err));
    chk("active_valid", W'(active_valid_o), W'(m_av));
    chk("f_weight", f_weight_o, m_f);
    chk("nz_mask", W'(nz_mask_o), W'(m_nz));
    chk("round", W'(round_o), W'(m_round));
    chk("last_round", W'(last_round_o), W'(m_round == max_round_i));
    busy_seen += int'(fill_busy_o);
    done_seen += int'(fill_done_o);
    err_seen  += int'(swap_err_o);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic pingpong(input logic [AW-1:0] base);
    fill_start_i = 1'b1; fill_base_i = base;
    weight_ld_i = 1'b1; rd_idx_i = IW'($urandom_range(0, DEPTH-1));
    cyc();
    fill_start_i = 1'b0;
    for (int i = 0; i < DEPTH + LAT + 2; i++) begin
      rd_idx_i = IW'($urandom_range(0, DEPTH-1));
      cyc();
    end
    swap_i = 1'b1; rd_idx_i = IW'($urandom_range(0, DEPTH-1));
    cyc();
    swap_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx_i = IW'(i);
      cyc();
    end
    weight_ld_i = 1'b0;
    chk("pp_new_word", f_weight_o, mem_word(base + AW'(DEPTH-1)));
    cyc();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] zw;
    model_reset();
    max_round_i = 3'd2;
    zw = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int r = 0; r < NR; r++)
      zw[r*FW +: FW] = (r == 0 || r == 5) ? 8'h00 : (zw[r*FW +: FW] | 8'h01);
    mem_m[16'h0021] = zw;

    repeat (2) cyc();
    chk("reset_nz_mask", W'(nz_mask_o), ZS ? W'(16'h0000) : W'(16'hFFFF));
    rd_weight_rst = 1'b0;
    cyc();

    // Fill from 0x10 with two early swaps (DRAIN cycle and last-capture cycle).
    busy_seen = 0; done_seen = 0; err_seen = 0;
    fill_start_i = 1'b1; fill_base_i = 16'h0010;
    cyc();
    fill_start_i = 1'b0;
    for (int i = 0; i < DEPTH + LAT; i++) begin
      swap_i = (i == DEPTH) || (i == DEPTH + LAT - 1);
      cyc();
    end
    swap_i = 1'b0;
    cyc();
    chk("fill1_busy_len", W'(busy_seen), W'(DEPTH + LAT));
    chk("fill1_done_cnt", W'(done_seen), W'(1));
    chk("early_swap_errs", W'(err_seen), W'(2));
    chk("early_swap_round", W'(round_o), W'(0));

    // Swap with a same-cycle load (no active bank yet), then read word 2.
    swap_i = 1'b1; weight_ld_i = 1'b1; rd_idx_i = '0;
    cyc();
    swap_i = 1'b0; rd_idx_i = IW'(2);
    cyc();
    weight_ld_i = 1'b0;
    chk("rd_idx2_word", f_weight_o, mem_word(16'h0012));
    chk("round_after_swap", W'(round_o), W'(1));
    cyc();

    // Ping-pong refills while reading every cycle; rounds 1 -> 2 -> 0.
    pingpong(16'h0100);
    chk("pp_round2", W'(round_o), W'(2));
    chk("pp_last_round", W'(last_round_o), W'(1));
    pingpong(16'hFFFE);
    chk("pp_round_wrap", W'(round_o), W'(0));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      fill_start_i = ($urandom_range(0, 3) == 0);
      fill_base_i  = AW'($urandom_range(0, 65535));
      swap_i       = ($urandom_range(0, 4) == 0);
      weight_ld_i  = 1'($urandom_range(0, 1));
      rd_idx_i     = IW'($urandom_range(0, DEPTH-1));
      if ($urandom_range(0, 49) == 0) max_round_i = RW'($urandom_range(0, 7));
      cyc();
    end
    fill_start_i = 1'b0; swap_i = 1'b0; weight_ld_i = 1'b0;
    while (m_left > 0) cyc();
    if (m_full) begin
      swap_i = 1'b1;
      cyc();
      swap_i = 1'b0;
    end
    cyc();

    // Reset after two reads of a fill; late returns must be dropped.
    fill_start_i = 1'b1; fill_base_i = 16'h0040;
    cyc();
    fill_start_i = 1'b0;
    repeat (2) cyc();
    rd_weight_rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_busy", W'(fill_busy_o), W'(0));
    chk("midrst_mem_rd", W'(mem_rd_o), W'(0));
    chk("midrst_active_valid", W'(active_valid_o), W'(0));
    chk("midrst_f_weight", f_weight_o, '0);
    chk("midrst_round", W'(round_o), W'(0));
    repeat (2) cyc();
    rd_weight_rst = 1'b0;
    repeat (4) cyc();

    // Fresh fill from 0x20 after the aborted one.
    fill_start_i = 1'b1; fill_base_i = 16'h0020;
    cyc();
    fill_start_i = 1'b0;
    repeat (DEPTH + LAT) cyc();
    swap_i = 1'b1;
    cyc();
    swap_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      weight_ld_i = 1'b1; rd_idx_i = IW'(i);
      cyc();
      weight_ld_i = 1'b0;
      chk($sformatf("refill_word%0d", i), f_weight_o, mem_word(16'h0020 + AW'(i)));
      if (i == 1) chk("zero_skip_mask", W'(nz_mask_o), ZS ? W'(16'hFFDE) : W'(16'hFFFF));
    end
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
